// File: rtl/knn_pkg.sv
// Shared definitions for the k-NN distance unit: FSM encoding, accumulator
// sizing rule and the per-chunk element count.
package knn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACC,
        EMIT
    } state_e;

    // Smallest accumulator that cannot wrap when summing `total` squares of W-bit differences.
    function automatic int unsigned min_dist_w(input int unsigned w, input int unsigned total);
        return 2 * w + $clog2(total);
    endfunction

    function automatic int unsigned chunk_len(input int unsigned max_elems,
                                              input int unsigned remaining);
        return (remaining < max_elems) ? remaining : max_elems;
    endfunction

endpackage

// File: rtl/knn_sq_diff.sv
// Combinational squared absolute difference of two unsigned W-bit values.
module knn_sq_diff #(
    parameter int W = 8
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] sq_o
);

    logic [W-1:0]   diff;
    logic [2*W-1:0] diff_ext;

    // NOTE: combinational logic uses blocking assignments so each line sees the value computed above it.
    always_comb begin
        diff     = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
        diff_ext = {{W{1'b0}}, diff};
        sq_o     = diff_ext * diff_ext;
    end

endmodule

// File: rtl/knn_distance_unit.sv
// Serial squared-Euclidean distance accumulator: consumes one chunk per read_done,
// requests further chunks until a full M*N sample is summed, then reports it.
module knn_distance_unit
    import knn_pkg::*;
#(
    parameter int M            = 28,
    parameter int N            = 28,
    parameter int W            = 8,
    parameter int MAX_ELEMENTS = 16,
    parameter int TYPE_W       = 4,
    parameter int DIST_W       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read_done,
    input  logic [W*MAX_ELEMENTS-1:0] input_data,
    input  logic [W*MAX_ELEMENTS-1:0] training_data,
    input  logic [TYPE_W-1:0]         training_data_type,
    output logic                      data_request,
    output logic                      done,
    output logic [DIST_W-1:0]         distance,
    output logic [TYPE_W-1:0]         dist_type,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned TOTAL = M * N;
    localparam int K_W = (MAX_ELEMENTS > 1) ? $clog2(MAX_ELEMENTS) : 1;
    localparam int C_W = $clog2(MAX_ELEMENTS + 1);
    localparam int T_W = $clog2(TOTAL + 1);

    if (DIST_W < min_dist_w(W, TOTAL)) begin : g_dist_w_check
        $error("knn_distance_unit: DIST_W too narrow for M*N squared differences");
    end

    state_e                             state_q;
    logic [MAX_ELEMENTS-1:0][W-1:0]     in_q;
    logic [MAX_ELEMENTS-1:0][W-1:0]     tr_q;
    logic [TYPE_W-1:0]                  type_q;
    logic [C_W-1:0]                     c_q;
    logic [K_W-1:0]                     k_q;
    logic [T_W-1:0]                     elem_total_q;
    logic [DIST_W-1:0]                  acc_q;

    logic [2*W-1:0]                     sq;
    logic [DIST_W-1:0]                  acc_d;
    logic [C_W-1:0]                     chunk_d;
    logic                               last_elem;

    knn_sq_diff #(.W(W)) u_sq_diff (
        .a_i  (in_q[k_q]),
        .b_i  (tr_q[k_q]),
        .sq_o (sq)
    );

    always_comb begin
        acc_d     = acc_q + DIST_W'(sq);
        chunk_d   = C_W'(chunk_len(MAX_ELEMENTS, TOTAL - 32'(elem_total_q)));
        last_elem = (C_W'(k_q) == (c_q - C_W'(1)));
        busy      = (state_q == ACC) || (state_q == EMIT);
    end

    // NOTE: state uses non-blocking assignments; the captured chunk registers are reset too,
    // so a reset never leaves stale lanes observable by the datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            in_q         <= '0;
            tr_q         <= '0;
            type_q       <= '0;
            c_q          <= '0;
            k_q          <= '0;
            elem_total_q <= '0;
            acc_q        <= '0;
            data_request <= 1'b0;
            done         <= 1'b0;
            distance     <= '0;
            dist_type    <= '0;
            overrun      <= 1'b0;
        end else begin
            data_request <= 1'b0;
            done         <= 1'b0;
            if (read_done && (state_q == ACC || state_q == EMIT)) begin
                overrun <= 1'b1;
            end
            case (state_q)
                IDLE, WAIT: begin
                    if (read_done) begin
                        in_q    <= input_data;
                        tr_q    <= training_data;
                        c_q     <= chunk_d;
                        k_q     <= '0;
                        state_q <= ACC;
                        if (state_q == IDLE) begin
                            type_q <= training_data_type;
                        end
                    end
                end
                ACC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 1'b1;
                    if (last_elem) begin
                        elem_total_q <= elem_total_q + T_W'(c_q);
                        state_q      <= EMIT;
                    end
                end
                EMIT: begin
                    if (elem_total_q < T_W'(TOTAL)) begin
                        data_request <= 1'b1;
                        state_q      <= WAIT;
                    end else begin
                        distance     <= acc_q;
                        dist_type    <= type_q;
                        done         <= 1'b1;
                        acc_q        <= '0;
                        elem_total_q <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knn_distance_unit.sv
// Directed bench: instance A is a 2x2 single-chunk unit, instance B a 2x3 unit
// that needs two chunks per sample (MAX_ELEMENTS=4 for both).
module tb_knn_distance_unit;

    logic        clk;
    logic        rst;

    logic        rd_a, req_a, done_a, busy_a, ovr_a;
    logic [31:0] in_a, tr_a, dist_a;
    logic [3:0]  ty_a, dtype_a;

    logic        rd_b, req_b, done_b, busy_b, ovr_b;
    logic [31:0] in_b, tr_b, dist_b;
    logic [3:0]  ty_b, dtype_b;

    int checks = 0;
    int errors = 0;
    int cyc;
    int reqs;
    logic got_req, got_done;

    knn_distance_unit #(.M(2), .N(2), .W(8), .MAX_ELEMENTS(4), .TYPE_W(4), .DIST_W(32)) dut_a (
        .clk(clk), .rst(rst), .read_done(rd_a), .input_data(in_a), .training_data(tr_a),
        .training_data_type(ty_a), .data_request(req_a), .done(done_a), .distance(dist_a),
        .dist_type(dtype_a), .busy(busy_a), .overrun(ovr_a)
    );

    knn_distance_unit #(.M(2), .N(3), .W(8), .MAX_ELEMENTS(4), .TYPE_W(4), .DIST_W(32)) dut_b (
        .clk(clk), .rst(rst), .read_done(rd_b), .input_data(in_b), .training_data(tr_b),
        .training_data_type(ty_b), .data_request(req_b), .done(done_b), .distance(dist_b),
        .dist_type(dtype_b), .busy(busy_b), .overrun(ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    function automatic logic [31:0] pack4(input logic [7:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called on a negedge; read_done is captured at the following posedge.
    task automatic strobe_a(input logic [31:0] i, t, input logic [3:0] ty);
        in_a = i; tr_a = t; ty_a = ty; rd_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [31:0] i, t, input logic [3:0] ty);
        in_b = i; tr_b = t; ty_b = ty; rd_b = 1'b1;
        @(negedge clk);
        rd_b = 1'b0;
    endtask

    // Counts posedges until done_a is seen; also counts any data_request seen on the way.
    task automatic wait_done_a(output int n, output int r);
        n = -1;
        r = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (req_a) r++;
            if (done_a) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_b(output int n, output logic saw_req, output logic saw_done);
        n = -1;
        saw_req = 1'b0;
        saw_done = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (req_b || done_b) begin
                n = i;
                saw_req = req_b;
                saw_done = done_b;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        rd_a = 1'b0; in_a = '0; tr_a = '0; ty_a = '0;
        rd_b = 1'b0; in_b = '0; tr_b = '0; ty_b = '0;

        // Reset state
        @(negedge clk);
        check("rst_done", done_a, 0);
        check("rst_req", req_a, 0);
        check("rst_dist", dist_a, 0);
        check("rst_type", dtype_a, 0);
        check("rst_ovr", ovr_a, 0);
        check("rst_busy", busy_a, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single chunk: 9+16+0+100
        strobe_a(pack4(10, 20, 30, 40), pack4(13, 16, 30, 50), 4'd3);
        check("single_busy", busy_a, 1);
        wait_done_a(cyc, reqs);
        check("single_latency", cyc, 5);
        check("single_no_req", reqs, 0);
        check("single_dist", dist_a, 125);
        check("single_type", dtype_a, 3);

        // Back-to-back: strobe in the cycle right after done
        strobe_a(pack4(1, 1, 1, 1), pack4(3, 3, 3, 3), 4'd7);
        check("b2b_prev_dist_held", dist_a, 125);
        wait_done_a(cyc, reqs);
        check("b2b_latency", cyc, 5);
        check("b2b_dist", dist_a, 16);
        check("b2b_type", dtype_a, 7);
        @(negedge clk);
        check("b2b_done_one_cycle", done_a, 0);
        check("b2b_dist_hold", dist_a, 16);
        check("b2b_no_overrun", ovr_a, 0);

        // Maximum magnitude: 4 * 255^2
        strobe_a(32'hFFFF_FFFF, 32'h0000_0000, 4'd15);
        wait_done_a(cyc, reqs);
        check("max_latency", cyc, 5);
        check("max_dist", dist_a, 260100);
        check("max_type", dtype_a, 15);

        // Multi-chunk on B: 4*9 + (9+1); upper lanes of chunk 2 carry junk
        @(negedge clk);
        strobe_b(pack4(5, 5, 5, 5), pack4(2, 2, 2, 2), 4'd9);
        wait_b(cyc, got_req, got_done);
        check("multi_req_latency", cyc, 5);
        check("multi_req_seen", got_req, 1);
        check("multi_req_not_done", got_done, 0);
        strobe_b(pack4(1, 1, 99, 99), pack4(4, 0, 0, 0), 4'd2);
        wait_b(cyc, got_req, got_done);
        check("multi_done_latency", cyc, 3);
        check("multi_done_seen", got_done, 1);
        check("multi_single_req", got_req, 0);
        check("multi_dist", dist_b, 46);
        check("multi_type", dtype_b, 9);

        // Overrun: second strobe during ACC must be ignored but flagged
        strobe_a(pack4(1, 2, 3, 4), pack4(0, 0, 0, 0), 4'd2);
        strobe_a(pack4(200, 200, 200, 200), pack4(0, 0, 0, 0), 4'd11);
        check("ovr_set", ovr_a, 1);
        wait_done_a(cyc, reqs);
        check("ovr_latency", cyc, 4);
        check("ovr_dist", dist_a, 30);
        check("ovr_type", dtype_a, 2);
        repeat (3) @(negedge clk);
        check("ovr_sticky", ovr_a, 1);

        // Reset in the middle of ACC
        strobe_a(pack4(9, 9, 9, 9), pack4(0, 0, 0, 0), 4'd5);
        @(negedge clk);
        check("mid_rst_busy_before", busy_a, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_dist", dist_a, 0);
        check("mid_rst_type", dtype_a, 0);
        check("mid_rst_ovr", ovr_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_dist_b", dist_b, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_no_pulse", done_a, 0);

        // Post-reset sample: 100+100+100+0
        strobe_a(pack4(100, 0, 50, 7), pack4(90, 10, 60, 7), 4'd6);
        wait_done_a(cyc, reqs);
        check("post_rst_latency", cyc, 5);
        check("post_rst_dist", dist_a, 300);
        check("post_rst_type", dtype_a, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/knn_distance_unit.md
Name: knn_distance_unit

Overview:
- Consumer stage directly downstream of the memory controller.
- On each `read_done` strobe it takes one chunk of input and training elements, then accumulates the squared Euclidean distance serially, one element per cycle.
- When a sample is incomplete it requests the next chunk with `data_request`. When all M*N elements are accumulated it presents the distance and the training type, and pulses `done`.
- Its outputs feed the k-nearest sorter and voter, which later produce `inferred_type` and `inference_done`.

Parameters:
- M, 28: image rows.
- N, 28: image columns; a sample has M*N elements.
- W, 8: element width in bits, unsigned.
- MAX_ELEMENTS, 16: maximum elements per chunk; matches the memory controller.
- TYPE_W, 4: width of the class label.
- DIST_W, 32: accumulator and distance width; must be at least 2*W + clog2(M*N).

Ports:
- clk, in, 1: clock; all logic is rising-edge.
- rst, in, 1: reset, asynchronous, active-low.
- read_done, in, 1: one-cycle strobe; the chunk and type inputs are valid this cycle.
- input_data, in, W*MAX_ELEMENTS: input chunk; element j sits at bits [W*(j+1)-1 -: W].
- training_data, in, W*MAX_ELEMENTS: training chunk, same packing as input_data.
- training_data_type, in, TYPE_W: label of the current training sample.
- data_request, out, 1: one-cycle pulse; asks for the next chunk of the same sample.
- done, out, 1: one-cycle pulse; distance and dist_type are valid.
- distance, out, DIST_W: squared distance of the last completed sample.
- dist_type, out, TYPE_W: label paired with distance.
- busy, out, 1: high in every state except IDLE and WAIT.
- overrun, out, 1: sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - acc=0, elem_total=0, k=0.
  - data_request=0, done=0, overrun=0.
  - distance=0, dist_type=0.
  - Captured chunk registers=0.
  - Reset mid-sample discards the partial accumulation; no pulse is emitted.
- Chunk length: c = min(MAX_ELEMENTS, M*N - elem_total). It is computed at capture time and is always ≥ 1.
- State IDLE (first chunk of a sample) and state WAIT (later chunks) behave the same on capture. If read_done=1:
  - latch both data vectors and c; set k=0; go to ACC.
  - In IDLE only, also latch training_data_type into type_reg.
- State ACC, one element per cycle:
  - d = |in[k] - tr[k]|, unsigned, W bits.
  - acc += d*d, using 2W-bit product, zero-extended to DIST_W.
  - k++.
  - When k == c-1, set elem_total += c and go to EMIT.
- State EMIT, one cycle:
  - If elem_total < M*N: data_request=1 for this cycle only; next state WAIT.
  - Else:
    - distance <= acc; dist_type <= type_reg; done=1 for this cycle only.
    - acc=0, elem_total=0; next state IDLE.
- Latency: read_done sampled at edge E0 gives ACC on edges E1..Ec. The data_request or done pulse is high between edges E(c+1) and E(c+2). This means c+1 cycles from strobe to pulse.
- data_request and done are never high in the same cycle.
- distance and dist_type hold their value until the next done.
- read_done while in ACC or EMIT:
  - Ignored; the captured data is unaffected.
  - overrun is set to 1 and stays set.
- Element ordering and chunk boundaries:
  - A chunk shorter than MAX_ELEMENTS ignores the upper, unused lanes.
  - When M*N ≤ MAX_ELEMENTS, every sample is a single chunk and data_request is never asserted.
- Arithmetic: no saturation. The DIST_W rule makes overflow impossible; an elaboration-time check enforces it.
- Maximum difference: all-0xFF against all-0x00 with W=8 contributes 65025 per element.

Decomposition:
- Shared package knn_pkg holds:
  - the state encoding IDLE/WAIT/ACC/EMIT;
  - a clog2-based helper constant for the minimum DIST_W;
  - the chunk-length function min(MAX_ELEMENTS, remaining).
- One natural sub-module: knn_sq_diff. It is combinational, takes two W-bit unsigned values and outputs the 2W-bit square of |a-b|. It is instantiated once inside the ACC datapath.

Test Plan:
- Single chunk, M=2 N=2 MAX=4 W=8:
  - Stimulus: in={10,20,30,40}, tr={13,16,30,50}, type=3, one read_done.
  - Expect: distance=9+16+0+100=125, dist_type=3. done pulses 5 cycles after read_done, and data_request never pulses.
- Multi-chunk, M=2 N=3 MAX=4 W=8:
  - Stimulus: chunk1 in all 5, tr all 2. After the data_request pulse (5 cycles after read_done), chunk2 with in={1,1}, tr={4,0}.
  - Expect: distance=4*9+9+1=46, done 3 cycles after the second read_done, and exactly one data_request.
- Maximum magnitude, M=2 N=2 MAX=4:
  - Stimulus: in all 255, tr all 0.
  - Expect: distance=260100, with no wrap.
- Back-to-back samples:
  - Stimulus: second sample's read_done 1 cycle after done, type=7.
  - Expect: acc restarts from 0, the second distance is independent of the first, and dist_type=7.
- Overrun:
  - Stimulus: assert read_done during ACC.
  - Expect: overrun=1 and stays high; the distance matches the original chunk.
- Reset mid-ACC:
  - Stimulus: pull rst low during ACC.
  - Expect: all outputs 0 immediately (asynchronous). The following sample computes correctly from acc=0.
